// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter (8N1, LSB first). Defining
// UART_TX_PARITY_EN adds an even-parity bit between the data and stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for the FIFO to become non-empty
// START  | start bit (low) for BAUD_DIV cycles
// DATA   | 8 data bits, LSB first, BAUD_DIV cycles each
// PARITY | even parity over the data byte (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high); pops the next byte straight into START if one is queued
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 5208,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       UART_TX
);

  localparam int          PW        = DEPTH_LOG2 + 1;
  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    head;
  logic          push, pop, load;

  state_t        state, state_d;
  logic [15:0]   cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          baud_done;
  logic          tx_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  // The pointer MSB differs only when the writer has lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign head      = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign push      = wr_en && (!full || pop);
  assign baud_done = (cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      overflow <= wr_en && !push;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 16'd1;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    load      = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        load  = !empty;
      end
      S_START: begin
        if (baud_done) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {1'b0, shreg[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          load    = !empty;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      pop     = 1'b1;
      shreg_d = head;
      cnt_d   = '0;
      state_d = S_START;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end

    // Line level is registered from the next state so it changes with the state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      UART_TX <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      UART_TX <= tx_d;
      busy    <= (state_d != S_IDLE);
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-timeline reference model predicts the
// serial line and flags every cycle; directed scenarios plus random traffic.
module tb_uart_tx_fifo;

  localparam int B     = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int   NBITS     = 11;
  localparam int   FRAME_CYC = 44;
  localparam logic PAR       = 1'b1;
`else
  localparam int   NBITS     = 10;
  localparam int   FRAME_CYC = 40;
  localparam logic PAR       = 1'b0;
`endif

  logic       clk, rst, wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, busy, UART_TX;

  uart_tx_fifo #(.BAUD_DIV(B), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow), .busy(busy),
    .UART_TX(UART_TX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: byte queue plus a frame timeline in edge numbers
  logic [7:0] mq[$];
  int         k, ready, fstart;
  logic [7:0] cur;

  // observation statistics
  int          busy_cycles, busy_rises, ovf_pulses;
  logic        prev_busy, full_seen, cap_en;
  logic [7:0]  ovf_data;
  logic [15:0] cap;
  int          ncap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    k = 0; ready = 0; fstart = 0; cur = 8'h00;
    prev_busy = 1'b0;
  endtask

  task automatic clear_stats();
    busy_cycles = 0; busy_rises = 0; ovf_pulses = 0;
    full_seen = 1'b0; ovf_data = 8'h00; cap = '0; ncap = 0;
  endtask

  task automatic step(input logic we, input logic [7:0] d);
    int   sz, j;
    logic pop, acc, exp_tx;
    wr_en = we; wr_data = d;
    @(posedge clk);
    k++;
    sz  = mq.size();
    pop = (k >= ready) && (sz > 0);
    if (pop) begin
      cur    = mq.pop_front();
      fstart = k;
      ready  = k + NBITS * B;
    end
    acc = we && ((sz < DEPTH) || pop);
    if (acc) mq.push_back(d);
    #1;
    exp_tx = 1'b1;
    if (k < ready) begin
      j = (k - fstart) / B;
      if (j == 0)                 exp_tx = 1'b0;
      else if (j <= 8)            exp_tx = cur[j-1];
      else if (j == 9 && PAR)     exp_tx = ^cur;
    end
    check("uart_tx",  UART_TX,  exp_tx);
    check("busy",     busy,     k < ready);
    check("empty",    empty,    mq.size() == 0);
    check("full",     full,     mq.size() == DEPTH);
    check("overflow", overflow, we && !acc);
    if (busy) busy_cycles++;
    if (busy && !prev_busy) busy_rises++;
    prev_busy = busy;
    if (overflow) begin ovf_pulses++; ovf_data = d; end
    if (full) full_seen = 1'b1;
    if (cap_en && (k < ready) && ((k - fstart) % B) == 1) begin
      cap = {cap[14:0], UART_TX};
      ncap++;
    end
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    logic reached;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    model_reset();
    clear_stats();
    cap_en = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx",    UART_TX,  1'b1);
    check("rst_busy",  busy,     1'b0);
    check("rst_ovf",   overflow, 1'b0);
    check("rst_empty", empty,    1'b1);
    check("rst_full",  full,     1'b0);
    rst = 1'b0;

    // single byte 0xA5
    clear_stats();
    cap_en = 1'b1;
    step(1'b1, 8'hA5);
    check("lat_tx_after_write", UART_TX, 1'b1);
    step(1'b0, 8'h00);
    check("lat_tx_start", UART_TX, 1'b0);
    idle(FRAME_CYC + 5);
    cap_en = 1'b0;
    check("single_busy_cycles", busy_cycles, FRAME_CYC);
    check("single_nsamples", ncap, NBITS);
`ifdef UART_TX_PARITY_EN
    check("single_bits", cap, 16'b010_1001_0101);
`else
    check("single_bits", cap, 16'b01_0100_1011);
`endif
    check("single_empty_end", empty, 1'b1);

    // back-to-back 0x01, 0x02, 0x03
    clear_stats();
    step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h03);
    idle(3 * FRAME_CYC + 10);
    check("b2b_busy_cycles", busy_cycles, 3 * FRAME_CYC);
    check("b2b_one_burst", busy_rises, 1);

    // overflow: 10 consecutive writes from idle
    clear_stats();
    for (int i = 0; i < 10; i++) step(1'b1, 8'h10 + 8'(i));
    check("ovf_pulses", ovf_pulses, 1);
    check("ovf_byte", ovf_data, 8'h19);
    check("ovf_full_seen", full_seen, 1'b1);
    idle(9 * FRAME_CYC + 10);
    check("ovf_busy_cycles", busy_cycles, 9 * FRAME_CYC);

    // pointer wrap: 20 writes one frame apart
    clear_stats();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom));
      idle(FRAME_CYC - 1);
    end
    idle(FRAME_CYC + 5);
    check("wrap_full_never", full_seen, 1'b0);
    check("wrap_busy_cycles", busy_cycles, 20 * FRAME_CYC);

    // reset during bit 3 of 0x5A with two bytes queued
    step(1'b1, 8'h5A); step(1'b1, 8'hC3); step(1'b1, 8'h3C);
    reached = 1'b0;
    for (int n = 0; n < 4 * FRAME_CYC && !reached; n++) begin
      if ((k < ready) && (k - fstart) == 4 * B + 1) reached = 1'b1;
      else step(1'b0, 8'h00);
    end
    check("midframe_reached", reached, 1'b1);
    check("midframe_queued", empty, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx",    UART_TX, 1'b1);
    check("arst_busy",  busy,    1'b0);
    check("arst_empty", empty,   1'b1);
    check("arst_full",  full,    1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    clear_stats();
    idle(2 * FRAME_CYC);
    check("after_rst_no_frames", busy_rises, 0);

`ifdef UART_TX_PARITY_EN
    // parity values
    clear_stats();
    cap_en = 1'b1;
    step(1'b1, 8'h07);
    idle(FRAME_CYC + 3);
    check("par07_bit", cap[1], 1'b1);
    check("par07_len", busy_cycles, 44);
    clear_stats();
    step(1'b1, 8'h03);
    idle(FRAME_CYC + 3);
    check("par03_bit", cap[1], 1'b0);
    cap_en = 1'b0;
`endif

    // random traffic: sparse, then bursty enough to overflow
    clear_stats();
    for (int i = 0; i < 1200; i++) begin
      step($urandom_range(0, 99) < ((i < 500) ? 3 : 40), 8'($urandom));
    end
    idle(DEPTH * FRAME_CYC + 20);
    check("rand_drained", empty, 1'b1);
    check("rand_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter BAUD_DIV SHALL default to 5208 and SHALL set the clock cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-003 Parameter DEPTH_LOG2 SHALL default to 3 and SHALL set the FIFO depth to 2**DEPTH_LOG2 bytes (8 by default).
REQ-004 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous reset, active-high.
REQ-006 Port wr_en  input  1  pushes wr_data into the FIFO this cycle; driven by the CPU result-start strobe.
REQ-007 Port wr_data  input  8  result byte to transmit.
REQ-008 Port full  output  1  FIFO holds 2**DEPTH_LOG2 bytes; combinational from the pointers.
REQ-009 Port empty  output  1  FIFO holds 0 bytes; combinational from the pointers.
REQ-010 Port overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 Port busy  output  1  transmit FSM is not in IDLE (registered).
REQ-012 Port UART_TX  output  1  serial line, idle high (registered).

Function
REQ-013 FIFO: circular buffer with read and write pointers each DEPTH_LOG2+1 bits wide; the extra MSB SHALL disambiguate full from empty.
REQ-014 A write SHALL be accepted when wr_en=1 and (full=0, or a pop occurs in the same cycle); otherwise the byte SHALL be dropped and overflow SHALL pulse for 1 cycle.
REQ-015 Pointers SHALL wrap modulo 2**(DEPTH_LOG2+1) with no special case at the wrap.
REQ-016 FSM states: IDLE, START, DATA, PARITY (present only under the macro in REQ-029), STOP.
REQ-017 IDLE: UART_TX=1. When empty=0, the FSM SHALL pop the head byte into a shift register and enter START on the same edge.
REQ-018 Each non-IDLE state SHALL last exactly BAUD_DIV cycles, timed by a 16-bit counter that reloads to 0 on every state entry.
REQ-019 START: UART_TX=0. DATA: 8 bits, LSB first, with a 3-bit bit index that advances every BAUD_DIV cycles; it leaves DATA after bit 7. STOP: UART_TX=1.
REQ-020 At the end of STOP, the FSM SHALL pop the next byte and go directly to START if empty=0 (back-to-back frames, no idle gap); otherwise it SHALL return to IDLE.
REQ-021 Latency: a write accepted at edge N into an empty FIFO with the FSM in IDLE SHALL drive UART_TX low after edge N+1.
REQ-022 Frame length SHALL be 10*BAUD_DIV cycles (11*BAUD_DIV with parity).
REQ-023 A write arriving mid-frame SHALL NOT disturb the frame in flight.
REQ-024 Simultaneous push and pop on an empty FIFO cannot occur: a pop requires empty=0 at the edge.

Reset
REQ-025 On rst: both pointers 0, FSM IDLE, baud counter 0, bit index 0, shift register 0x00.
REQ-026 Reset values of outputs: UART_TX=1, busy=0, overflow=0, empty=1, full=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) and SHALL discard the FIFO contents; no partial frame resumes.
REQ-028 FIFO storage contents need not be reset.

Configuration
REQ-029 Macro UART_TX_PARITY_EN: when defined, a PARITY state of BAUD_DIV cycles SHALL follow DATA and transmit even parity (XOR of the 8 data bits).
REQ-030 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP, and no parity logic SHALL be synthesised.

Verification (BAUD_DIV=4, DEPTH_LOG2=3, macro undefined unless stated)
REQ-031 Single byte: write 0xA5 once while idle -> UART_TX reads 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles (40 cycles total); busy=1 throughout the frame; then IDLE with empty=1.
REQ-032 Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous frames totalling 120 cycles, with no high gap between the STOP of one frame and the START of the next.
REQ-033 Overflow: write 10 bytes 0x10..0x19 on consecutive cycles from idle -> the first byte is popped, so 9 are accepted; full=1 and overflow pulses for byte 0x19 only; 0x10..0x18 are transmitted in order.
REQ-034 Wrap: 20 writes spaced one frame apart -> every byte is transmitted correctly across the pointer wrap, and full never asserts.
REQ-035 Reset mid-frame: assert rst during bit 3 of 0x5A with 2 bytes queued -> UART_TX=1, busy=0, empty=1 immediately; no further frames after rst is released.
REQ-036 With UART_TX_PARITY_EN defined: write 0x07 -> parity bit is 1 and the frame is 44 cycles; write 0x03 -> parity bit is 0.
